// File: rtl/handshake_constant_match_pkg.sv
`default_nettype none
// ============================================================================
// Module      : handshake_constant_match_pkg
// Description : Shared dataflow definitions: handshake slot state encoding
//               and a width-generic saturating increment.
// Revision    : 1.0 - initial release
// ============================================================================
package handshake_constant_match_pkg;

    // One-entry handshake slot occupancy.
    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Increment a WIDTH-bit counter held in the low bits of a 64-bit value,
    // holding at all-ones instead of wrapping. Callers size the result back
    // down with a width cast.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? max_val : (value + 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/handshake_ctrl_slot.sv
`default_nettype none
// ============================================================================
// Module      : handshake_ctrl_slot
// Description : One-entry dataless valid/ready output slot with
//               same-cycle pass-through when the consumer drains it.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_ctrl_slot
    import handshake_constant_match_pkg::*;
(
    input  logic clk,
    input  logic rst,        // synchronous, active-low
    input  logic load,       // a token enters the slot this cycle
    output logic ins_ready,  // slot can take a token this cycle
    output logic valid,
    input  logic ready
);

    slot_state_e r_state;
    slot_state_e w_state_next;

    // Slot occupancy register; reset discards any pending token.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next occupancy and handshake outputs; a load while draining keeps FULL.
    always_comb begin
        w_state_next = r_state;
        valid        = (r_state == SLOT_FULL);
        ins_ready    = rst && ((r_state == SLOT_EMPTY) || ready);
        if (load) begin
            w_state_next = SLOT_FULL;
        end else if (ready) begin
            w_state_next = SLOT_EMPTY;
        end
    end

endmodule
`default_nettype wire

// File: rtl/handshake_constant_match.sv
`default_nettype none
// ============================================================================
// Module      : handshake_constant_match
// Description : Dataflow sink that checks each accepted token against a
//               constant, emits a control token, and keeps saturating
//               match/mismatch counters plus a sticky first-error capture.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_constant_match
    import handshake_constant_match_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter logic [63:0] CONST_VALUE   = 64'b010101,
    parameter int          CNT_WIDTH     = 16,
    parameter int          DROP_MISMATCH = 0
) (
    input  logic                  clk,
    input  logic                  rst,            // synchronous, active-low
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  ctrl_valid,
    input  logic                  ctrl_ready,
    input  logic                  err_clear,
    output logic [CNT_WIDTH-1:0]  match_count,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic                  err_sticky,
    output logic [DATA_WIDTH-1:0] first_bad
);

    // Expected token value resized to the data width.
    localparam logic [DATA_WIDTH-1:0] c_CONST = CONST_VALUE[DATA_WIDTH-1:0];
    localparam logic                  c_DROP  = (DROP_MISMATCH != 0);

    logic                  w_slot_ready;
    logic                  w_accept;
    logic                  w_match;
    logic                  w_load;
    logic [CNT_WIDTH-1:0]  r_match_count;
    logic [CNT_WIDTH-1:0]  r_mismatch_count;
    logic                  r_err_sticky;
    logic [DATA_WIDTH-1:0] r_first_bad;

    assign w_accept = ins_valid && w_slot_ready;
    assign w_match  = (ins == c_CONST);
    // Mismatches still occupy the slot unless drop mode discards them.
    assign w_load   = w_accept && (w_match || !c_DROP);

    handshake_ctrl_slot u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .ins_ready (w_slot_ready),
        .valid     (ctrl_valid),
        .ready     (ctrl_ready)
    );

    // Saturating statistics counters, updated on the accept edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_match_count    <= '0;
            r_mismatch_count <= '0;
        end else if (w_accept) begin
            if (w_match) begin
                r_match_count <= CNT_WIDTH'(sat_inc(64'(r_match_count), CNT_WIDTH));
            end else begin
                r_mismatch_count <= CNT_WIDTH'(sat_inc(64'(r_mismatch_count), CNT_WIDTH));
            end
        end
    end

    // Sticky error and first-offender capture; a mismatch beats a clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_sticky <= 1'b0;
            r_first_bad  <= '0;
        end else if (w_accept && !w_match) begin
            r_err_sticky <= 1'b1;
            if (!r_err_sticky || err_clear) begin
                r_first_bad <= ins;
            end
        end else if (err_clear) begin
            r_err_sticky <= 1'b0;
            r_first_bad  <= '0;
        end
    end

    assign ins_ready      = w_slot_ready;
    assign match_count    = r_match_count;
    assign mismatch_count = r_mismatch_count;
    assign err_sticky     = r_err_sticky;
    assign first_bad      = r_first_bad;

endmodule
`default_nettype wire

// File: tb/tb_handshake_constant_match.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake_constant_match
// Description : Directed self-checking bench for handshake_constant_match,
//               covering default, drop-mode and narrow-counter builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_constant_match;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Default build
    logic [31:0] ins = '0;
    logic        ins_valid = 1'b0, ins_ready, ctrl_valid, ctrl_ready = 1'b1, err_clear = 1'b0;
    logic [15:0] match_count, mismatch_count;
    logic        err_sticky;
    logic [31:0] first_bad;

    // Drop-mode build
    logic [31:0] d_ins = '0;
    logic        d_valid = 1'b0, d_ready, d_ctrl_valid, d_ctrl_ready = 1'b1;
    logic [15:0] d_match, d_mismatch;
    logic        d_err;
    logic [31:0] d_first_bad;

    // Narrow-counter build
    logic [31:0] s_ins = 32'h15;
    logic        s_valid = 1'b0, s_ready, s_ctrl_valid;
    logic [3:0]  s_match, s_mismatch;
    logic        s_err;
    logic [31:0] s_first_bad;

    int n_checks = 0;
    int n_pass   = 0;
    int n_deliv  = 0;
    int d_deliv  = 0;
    int base;

    handshake_constant_match dut (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .err_clear(err_clear),
        .match_count(match_count), .mismatch_count(mismatch_count),
        .err_sticky(err_sticky), .first_bad(first_bad)
    );

    handshake_constant_match #(.DROP_MISMATCH(1)) dut_drop (
        .clk(clk), .rst(rst), .ins(d_ins), .ins_valid(d_valid), .ins_ready(d_ready),
        .ctrl_valid(d_ctrl_valid), .ctrl_ready(d_ctrl_ready), .err_clear(1'b0),
        .match_count(d_match), .mismatch_count(d_mismatch),
        .err_sticky(d_err), .first_bad(d_first_bad)
    );

    handshake_constant_match #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .ins(s_ins), .ins_valid(s_valid), .ins_ready(s_ready),
        .ctrl_valid(s_ctrl_valid), .ctrl_ready(1'b1), .err_clear(1'b0),
        .match_count(s_match), .mismatch_count(s_mismatch),
        .err_sticky(s_err), .first_bad(s_first_bad)
    );

    // Count delivered control tokens on each build.
    always @(posedge clk) begin
        if (ctrl_valid && ctrl_ready)     n_deliv <= n_deliv + 1;
        if (d_ctrl_valid && d_ctrl_ready) d_deliv <= d_deliv + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with a valid token offered
        ins_valid = 1'b1; ins = 32'h15;
        repeat (3) tick();
        check("rst_ins_ready",  64'(ins_ready), 64'd0);
        check("rst_ctrl_valid", 64'(ctrl_valid), 64'd0);
        check("rst_match",      64'(match_count), 64'd0);
        check("rst_mismatch",   64'(mismatch_count), 64'd0);
        check("rst_err",        64'(err_sticky), 64'd0);
        check("rst_first_bad",  64'(first_bad), 64'd0);
        ins_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rel_ins_ready",  64'(ins_ready), 64'd1);
        check("rel_ctrl_valid", 64'(ctrl_valid), 64'd0);

        // Streaming: 10 matching tokens, one per cycle
        base = n_deliv;
        ins = 32'h15; ins_valid = 1'b1; ctrl_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("stream_valid_%0d", i), 64'(ctrl_valid), 64'd1);
        end
        ins_valid = 1'b0;
        tick();
        check("stream_drain",   64'(ctrl_valid), 64'd0);
        check("stream_deliv",   64'(n_deliv - base), 64'd10);
        check("stream_match",   64'(match_count), 64'd10);
        check("stream_err",     64'(err_sticky), 64'd0);

        // Backpressure then pass-through
        base = n_deliv;
        ctrl_ready = 1'b0; ins_valid = 1'b1; ins = 32'h15;
        tick();
        check("bp_valid",       64'(ctrl_valid), 64'd1);
        check("bp_ins_ready",   64'(ins_ready), 64'd0);
        tick();
        check("bp_hold_valid",  64'(ctrl_valid), 64'd1);
        check("bp_hold_ready",  64'(ins_ready), 64'd0);
        check("bp_hold_match",  64'(match_count), 64'd11);
        ctrl_ready = 1'b1;
        #1;
        check("bp_release_rdy", 64'(ins_ready), 64'd1);
        tick();
        check("pt_valid",       64'(ctrl_valid), 64'd1);
        check("pt_match",       64'(match_count), 64'd12);
        ins_valid = 1'b0;
        tick();
        check("pt_drain",       64'(ctrl_valid), 64'd0);
        check("pt_deliv",       64'(n_deliv - base), 64'd2);

        // Error capture
        ins_valid = 1'b1; ins = 32'h15; tick();
        ins = 32'h07; tick();
        ins = 32'h09; tick();
        ins_valid = 1'b0;
        check("err_mismatch",   64'(mismatch_count), 64'd2);
        check("err_match",      64'(match_count), 64'd13);
        check("err_sticky",     64'(err_sticky), 64'd1);
        check("err_first_bad",  64'(first_bad), 64'h07);
        // Clear coinciding with a mismatch: the set wins
        ins_valid = 1'b1; ins = 32'h0A; err_clear = 1'b1;
        tick();
        ins_valid = 1'b0; err_clear = 1'b0;
        check("clr_set_err",    64'(err_sticky), 64'd1);
        check("clr_set_first",  64'(first_bad), 64'h0A);
        check("clr_set_mm",     64'(mismatch_count), 64'd3);
        // Plain clear
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clr_err",        64'(err_sticky), 64'd0);
        check("clr_first",      64'(first_bad), 64'd0);
        check("clr_keeps_mm",   64'(mismatch_count), 64'd3);
        check("clr_keeps_m",    64'(match_count), 64'd13);

        // Drop mode: 0x15, 0x00, 0x15
        d_valid = 1'b1; d_ins = 32'h15; tick();
        check("drop_v0",        64'(d_ctrl_valid), 64'd1);
        d_ins = 32'h00; tick();
        check("drop_v1",        64'(d_ctrl_valid), 64'd0);
        d_ins = 32'h15; tick();
        check("drop_v2",        64'(d_ctrl_valid), 64'd1);
        d_valid = 1'b0; tick();
        check("drop_deliv",     64'(d_deliv), 64'd2);
        check("drop_match",     64'(d_match), 64'd2);
        check("drop_mismatch",  64'(d_mismatch), 64'd1);
        check("drop_err",       64'(d_err), 64'd1);
        check("drop_first_bad", 64'(d_first_bad), 64'd0);

        // Saturation with 4-bit counters: 20 matching tokens
        s_valid = 1'b1;
        repeat (14) tick();
        check("sat_14",         64'(s_match), 64'd14);
        tick();
        check("sat_15",         64'(s_match), 64'd15);
        repeat (5) tick();
        s_valid = 1'b0;
        check("sat_hold",       64'(s_match), 64'd15);
        check("sat_mismatch",   64'(s_mismatch), 64'd0);

        // Reset mid-operation discards a pending token
        ctrl_ready = 1'b0; ins_valid = 1'b1; ins = 32'h15;
        tick();
        check("mid_full",       64'(ctrl_valid), 64'd1);
        ins_valid = 1'b0; rst = 1'b0;
        tick();
        check("mid_rst_valid",  64'(ctrl_valid), 64'd0);
        check("mid_rst_match",  64'(match_count), 64'd0);
        check("mid_rst_mm",     64'(mismatch_count), 64'd0);
        check("mid_rst_ready",  64'(ins_ready), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
